// File: rtl/enigma_rotor_ctrl.sv
// Odometer-style rotor stepping controller for the enigma_1 pipeline.
// Supplies current rotor positions plus per-stage delayed copies for in-flight symbols.
module enigma_rotor_ctrl #(
  parameter logic [6:0] R1_INIT_VALUE = 7'd1,
  parameter logic [6:0] R2_INIT_VALUE = 7'd1,
  parameter logic [6:0] R3_INIT_VALUE = 7'd1,
  parameter logic [6:0] R1_NOTCH      = 7'd17,
  parameter logic [6:0] R2_NOTCH      = 7'd5,
  parameter logic [6:0] LETTERS       = 7'd26
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rotors_rst_i,
  input  logic            load_i,
  input  logic [6:0]      r1_pos_i,
  input  logic [6:0]      r2_pos_i,
  input  logic [6:0]      r3_pos_i,
  input  logic            en_val_i,
  output logic [6:0]      r1_o,
  output logic [5:1][6:0] r1_d_o,
  output logic [6:0]      r2_o,
  output logic [4:1][6:0] r2_d_o,
  output logic [6:0]      r3_o,
  output logic [3:1][6:0] r3_d_o,
  output logic [1:0]      carry_o
);

  function automatic logic [6:0] f_step(input logic [6:0] pos);
    logic [6:0] v_res;
    if (pos == LETTERS) begin
      v_res = 7'd1;
    end else begin
      v_res = pos + 7'd1;
    end
    return v_res;
  endfunction

  // Key-setting values outside 1..LETTERS collapse to position 1
  function automatic logic [6:0] f_legal(input logic [6:0] pos);
    logic [6:0] v_res;
    if ((pos != 7'd0) && (pos <= LETTERS)) begin
      v_res = pos;
    end else begin
      v_res = 7'd1;
    end
    return v_res;
  endfunction

  logic [6:0]      r_r1;
  logic [6:0]      r_r2;
  logic [6:0]      r_r3;
  logic [5:1][6:0] r_r1_d;
  logic [4:1][6:0] r_r2_d;
  logic [3:1][6:0] r_r3_d;
  logic [1:0]      r_carry;

  logic [6:0]      w_r1_nxt;
  logic [6:0]      w_r2_nxt;
  logic [6:0]      w_r3_nxt;
  logic [1:0]      w_carry_nxt;

  // Next rotor positions: rotors_rst_i > load_i > step
  always_comb begin
    w_r1_nxt    = r_r1;
    w_r2_nxt    = r_r2;
    w_r3_nxt    = r_r3;
    w_carry_nxt = 2'b00;
    if (rotors_rst_i) begin
      w_r1_nxt = R1_INIT_VALUE;
      w_r2_nxt = R2_INIT_VALUE;
      w_r3_nxt = R3_INIT_VALUE;
    end else if (load_i) begin
      w_r1_nxt = f_legal(r1_pos_i);
      w_r2_nxt = f_legal(r2_pos_i);
      w_r3_nxt = f_legal(r3_pos_i);
    end else if (en_val_i) begin
      w_r1_nxt = f_step(r_r1);
      if (r_r1 == R1_NOTCH) begin
        w_r2_nxt       = f_step(r_r2);
        w_carry_nxt[0] = 1'b1;
        if (r_r2 == R2_NOTCH) begin
          w_r3_nxt       = f_step(r_r3);
          w_carry_nxt[1] = 1'b1;
        end else begin
          w_r3_nxt = r_r3;
        end
      end else begin
        w_r2_nxt = r_r2;
      end
    end else begin
      w_r1_nxt = r_r1;
    end
  end

  // Position/carry registers; delay lines shift every clock from pre-step positions
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_r1    <= R1_INIT_VALUE;
      r_r2    <= R2_INIT_VALUE;
      r_r3    <= R3_INIT_VALUE;
      r_r1_d  <= {5{R1_INIT_VALUE}};
      r_r2_d  <= {4{R2_INIT_VALUE}};
      r_r3_d  <= {3{R3_INIT_VALUE}};
      r_carry <= 2'b00;
    end else begin
      r_r1    <= w_r1_nxt;
      r_r2    <= w_r2_nxt;
      r_r3    <= w_r3_nxt;
      r_r1_d  <= {r_r1_d[4:1], r_r1};
      r_r2_d  <= {r_r2_d[3:1], r_r2};
      r_r3_d  <= {r_r3_d[2:1], r_r3};
      r_carry <= w_carry_nxt;
    end
  end

  assign r1_o    = r_r1;
  assign r2_o    = r_r2;
  assign r3_o    = r_r3;
  assign r1_d_o  = r_r1_d;
  assign r2_d_o  = r_r2_d;
  assign r3_d_o  = r_r3_d;
  assign carry_o = r_carry;

endmodule

// File: tb/tb_enigma_rotor_ctrl.sv
// Directed-vector bench for enigma_rotor_ctrl with hand-computed expectations.
module tb_enigma_rotor_ctrl;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            rotors_rst_i = 1'b0;
  logic            load_i = 1'b0;
  logic [6:0]      r1_pos_i = 7'd0;
  logic [6:0]      r2_pos_i = 7'd0;
  logic [6:0]      r3_pos_i = 7'd0;
  logic            en_val_i = 1'b0;
  logic [6:0]      r1_o;
  logic [5:1][6:0] r1_d_o;
  logic [6:0]      r2_o;
  logic [4:1][6:0] r2_d_o;
  logic [6:0]      r3_o;
  logic [3:1][6:0] r3_d_o;
  logic [1:0]      carry_o;

  int n_checks = 0;
  int n_fail   = 0;

  enigma_rotor_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rotors_rst_i (rotors_rst_i),
    .load_i       (load_i),
    .r1_pos_i     (r1_pos_i),
    .r2_pos_i     (r2_pos_i),
    .r3_pos_i     (r3_pos_i),
    .en_val_i     (en_val_i),
    .r1_o         (r1_o),
    .r1_d_o       (r1_d_o),
    .r2_o         (r2_o),
    .r2_d_o       (r2_d_o),
    .r3_o         (r3_o),
    .r3_d_o       (r3_d_o),
    .carry_o      (carry_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_pos(input string tag, input logic [6:0] e1, input logic [6:0] e2,
                         input logic [6:0] e3, input logic [1:0] ec);
    chk({tag, ".r1"}, {57'd0, r1_o}, {57'd0, e1});
    chk({tag, ".r2"}, {57'd0, r2_o}, {57'd0, e2});
    chk({tag, ".r3"}, {57'd0, r3_o}, {57'd0, e3});
    chk({tag, ".carry"}, {62'd0, carry_o}, {62'd0, ec});
  endtask

  task automatic load_rotors(input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3);
    load_i   = 1'b1;
    r1_pos_i = p1;
    r2_pos_i = p2;
    r3_pos_i = p3;
    tick();
    load_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk_pos("rst", 7'd1, 7'd1, 7'd1, 2'b00);
    chk("rst.r1_d", {29'd0, r1_d_o}, {29'd0, {5{7'd1}}});
    chk("rst.r2_d", {36'd0, r2_d_o}, {36'd0, {4{7'd1}}});
    chk("rst.r3_d", {43'd0, r3_d_o}, {43'd0, {3{7'd1}}});
    rst_i = 1'b0;
    tick();
    chk_pos("idle", 7'd1, 7'd1, 7'd1, 2'b00);

    // 16 valids then the notch step
    en_val_i = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk_pos("v16", 7'd17, 7'd1, 7'd1, 2'b00);
    chk("v16.r1_d1", {57'd0, r1_d_o[1]}, 64'd16);
    tick();
    en_val_i = 1'b0;
    chk_pos("v17", 7'd18, 7'd2, 7'd1, 2'b01);
    chk("v17.r1_d1", {57'd0, r1_d_o[1]}, 64'd17);
    chk("v17.r1_d2", {57'd0, r1_d_o[2]}, 64'd16);
    chk("v17.r2_d1", {57'd0, r2_d_o[1]}, 64'd1);
    tick();
    chk_pos("v17+1", 7'd18, 7'd2, 7'd1, 2'b00);
    chk("v17+1.r2_d1", {57'd0, r2_d_o[1]}, 64'd2);

    // Double carry with r3 wrap
    load_rotors(7'd17, 7'd5, 7'd26);
    chk_pos("ld17_5_26", 7'd17, 7'd5, 7'd26, 2'b00);
    en_val_i = 1'b1;
    tick();
    en_val_i = 1'b0;
    chk_pos("dbl", 7'd18, 7'd6, 7'd1, 2'b11);
    chk("dbl.r3_d1", {57'd0, r3_d_o[1]}, 64'd26);

    // r1 wrap and delay-line propagation
    load_rotors(7'd26, 7'd3, 7'd4);
    en_val_i = 1'b1;
    tick();
    en_val_i = 1'b0;
    chk_pos("wrap", 7'd1, 7'd3, 7'd4, 2'b00);
    chk("wrap.r1_d1", {57'd0, r1_d_o[1]}, 64'd26);
    for (int i = 0; i < 4; i++) tick();
    chk("wrap.r1_d5", {57'd0, r1_d_o[5]}, 64'd26);
    chk("wrap.r1_d4", {57'd0, r1_d_o[4]}, 64'd1);
    chk("wrap.r2_d4", {57'd0, r2_d_o[4]}, 64'd3);
    chk("wrap.r3_d3", {57'd0, r3_d_o[3]}, 64'd4);

    // rotors_rst_i beats valid; delay lines still take the old positions
    load_rotors(7'd10, 7'd20, 7'd3);
    rotors_rst_i = 1'b1;
    en_val_i     = 1'b1;
    tick();
    rotors_rst_i = 1'b0;
    en_val_i     = 1'b0;
    chk_pos("srst", 7'd1, 7'd1, 7'd1, 2'b00);
    chk("srst.r1_d1", {57'd0, r1_d_o[1]}, 64'd10);
    chk("srst.r2_d1", {57'd0, r2_d_o[1]}, 64'd20);
    chk("srst.r3_d1", {57'd0, r3_d_o[1]}, 64'd3);

    // load beats valid
    en_val_i = 1'b1;
    load_rotors(7'd17, 7'd5, 7'd5);
    en_val_i = 1'b0;
    chk_pos("ld_pri", 7'd17, 7'd5, 7'd5, 2'b00);

    // Out-of-range load values
    load_rotors(7'd0, 7'd40, 7'd27);
    chk_pos("ld_bad", 7'd1, 7'd1, 7'd1, 2'b00);
    load_rotors(7'd26, 7'd26, 7'd26);
    chk_pos("ld_max", 7'd26, 7'd26, 7'd26, 2'b00);

    // Async reset mid-stream clears immediately
    load_rotors(7'd17, 7'd5, 7'd9);
    en_val_i = 1'b1;
    tick();
    chk_pos("pre_rst", 7'd18, 7'd6, 7'd10, 2'b11);
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    chk_pos("async_rst", 7'd1, 7'd1, 7'd1, 2'b00);
    chk("async_rst.r1_d", {29'd0, r1_d_o}, {29'd0, {5{7'd1}}});
    chk("async_rst.r3_d", {43'd0, r3_d_o}, {43'd0, {3{7'd1}}});
    en_val_i = 1'b0;
    #10;
    rst_i = 1'b0;
    tick();
    chk_pos("post_rst", 7'd1, 7'd1, 7'd1, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
